// File: rtl/syndrome_round_loader_pkg.sv
// Shared types and constants for the syndrome round loader: state encoding,
// result field widths and a constant-evaluable max helper.
package syndrome_loader_pkg;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_RESYNC = 3'd1,
        ST_START  = 3'd2,
        ST_DECODE = 3'd3,
        ST_REPORT = 3'd4
    } loader_state_e;

    localparam int ROUND_ID_WIDTH = 16;
    localparam int CYCLE_WIDTH    = 32;
    localparam int ITER_WIDTH     = 8;

    function automatic int max(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/syndrome_round_loader_watchdog.sv
// Decode watchdog: counts enabled cycles from a clear and flags when the
// count reaches TIMEOUT_CYCLES, saturating there.
module round_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_r;

    // Cycle counter, cleared outside decode and held once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIMIT);

endmodule

// File: rtl/syndrome_round_loader.sv
// Ingest stage: assembles one round of syndrome words, pulses the decoder,
// waits for its result (or the watchdog) and reports it over valid/ready.
module syndrome_round_loader
    import syndrome_loader_pkg::*;
#(
    parameter int CODE_DISTANCE_X = 5,
    parameter int CODE_DISTANCE_Z = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic                        new_round_start,
    output logic [CODE_DISTANCE_X*CODE_DISTANCE_Z*max(CODE_DISTANCE_X, CODE_DISTANCE_Z)-1:0] is_error_syndromes,
    input  logic                        result_valid,
    input  logic [CYCLE_WIDTH-1:0]      cycle_counter,
    input  logic [ITER_WIDTH-1:0]       iteration_counter,
    input  logic                        deadlock,
    input  logic                        final_cardinality,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [ROUND_ID_WIDTH-1:0]   r_round_id,
    output logic [CYCLE_WIDTH-1:0]      r_cycles,
    output logic [ITER_WIDTH-1:0]       r_iterations,
    output logic                        r_deadlock,
    output logic                        r_cardinality,
    output logic                        r_timeout,
    output logic                        framing_error
);
    localparam int MEASUREMENT_ROUNDS = max(CODE_DISTANCE_X, CODE_DISTANCE_Z);
    localparam int PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS;
    localparam int WORDS    = (PU_COUNT + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    loader_state_e             state_r, state_next_s;
    logic [IDX_W-1:0]          word_idx_r, word_idx_next_s;
    logic [PU_COUNT-1:0]       syndromes_r, syndromes_next_s;
    logic                      s_ready_r, start_r, framing_r, first_decode_r;
    logic                      framing_set_s, capture_s, timeout_s, handshake_s;
    logic                      accept_s, expired_s;
    logic                      r_valid_r, r_deadlock_r, r_cardinality_r, r_timeout_r;
    logic [ROUND_ID_WIDTH-1:0] r_round_id_r;
    logic [CYCLE_WIDTH-1:0]    r_cycles_r;
    logic [ITER_WIDTH-1:0]     r_iterations_r;

    assign accept_s = s_valid & s_ready_r;

    round_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (state_r != ST_DECODE),
        .enable  (state_r == ST_DECODE),
        .expired (expired_s)
    );

    // Next-state, word assembly and event decode for the round sequencer.
    always_comb begin
        state_next_s     = state_r;
        word_idx_next_s  = word_idx_r;
        syndromes_next_s = syndromes_r;
        framing_set_s    = 1'b0;
        capture_s        = 1'b0;
        timeout_s        = 1'b0;
        handshake_s      = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (accept_s) begin
                    for (int i = 0; i < PU_COUNT; i++) begin
                        if (i / DATA_WIDTH == int'(word_idx_r)) begin
                            syndromes_next_s[i] = s_data[i % DATA_WIDTH];
                        end else begin
                            syndromes_next_s[i] = syndromes_r[i];
                        end
                    end
                    if (word_idx_r == LAST_IDX) begin
                        word_idx_next_s = '0;
                        if (s_last) begin
                            state_next_s = ST_START;
                        end else begin
                            framing_set_s = 1'b1;
                            state_next_s  = ST_RESYNC;
                        end
                    end else if (s_last) begin
                        // Short round: drop it and wait for a fresh first word.
                        framing_set_s   = 1'b1;
                        word_idx_next_s = '0;
                    end else begin
                        word_idx_next_s = word_idx_r + IDX_W'(1);
                    end
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_RESYNC: begin
                if (accept_s && s_last) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_RESYNC;
                end
            end
            ST_START: begin
                state_next_s = ST_DECODE;
            end
            ST_DECODE: begin
                // A result_valid level left over from the previous round is masked.
                if (result_valid && !first_decode_r) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_REPORT;
                end else if (expired_s) begin
                    capture_s    = 1'b1;
                    timeout_s    = 1'b1;
                    state_next_s = ST_REPORT;
                end else begin
                    state_next_s = ST_DECODE;
                end
            end
            ST_REPORT: begin
                if (r_ready) begin
                    handshake_s  = 1'b1;
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_REPORT;
                end
            end
            default: begin
                state_next_s    = ST_LOAD;
                word_idx_next_s = '0;
            end
        endcase
    end

    // Sequencer state and registered load-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_LOAD;
            word_idx_r     <= '0;
            syndromes_r    <= '0;
            s_ready_r      <= 1'b0;
            start_r        <= 1'b0;
            framing_r      <= 1'b0;
            first_decode_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            word_idx_r     <= word_idx_next_s;
            syndromes_r    <= syndromes_next_s;
            s_ready_r      <= (state_next_s == ST_LOAD) || (state_next_s == ST_RESYNC);
            start_r        <= (state_next_s == ST_START);
            framing_r      <= framing_r | framing_set_s;
            first_decode_r <= (state_r == ST_START);
        end
    end

    // Result channel: capture on decoder done or watchdog, release on handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid_r       <= 1'b0;
            r_round_id_r    <= '0;
            r_cycles_r      <= '0;
            r_iterations_r  <= '0;
            r_deadlock_r    <= 1'b0;
            r_cardinality_r <= 1'b0;
            r_timeout_r     <= 1'b0;
        end else if (capture_s) begin
            r_valid_r       <= 1'b1;
            r_cycles_r      <= cycle_counter;
            r_iterations_r  <= iteration_counter;
            r_deadlock_r    <= deadlock | timeout_s;
            r_cardinality_r <= final_cardinality;
            r_timeout_r     <= timeout_s;
        end else if (handshake_s) begin
            r_valid_r    <= 1'b0;
            r_round_id_r <= r_round_id_r + ROUND_ID_WIDTH'(1);
        end else begin
            r_valid_r <= r_valid_r;
        end
    end

    assign s_ready            = s_ready_r;
    assign new_round_start    = start_r;
    assign is_error_syndromes = syndromes_r;
    assign framing_error      = framing_r;
    assign r_valid            = r_valid_r;
    assign r_round_id         = r_round_id_r;
    assign r_cycles           = r_cycles_r;
    assign r_iterations       = r_iterations_r;
    assign r_deadlock         = r_deadlock_r;
    assign r_cardinality      = r_cardinality_r;
    assign r_timeout          = r_timeout_r;

endmodule

// File: tb/tb_syndrome_round_loader.sv
// Randomized bench for syndrome_round_loader: a round-level behavioural model
// predicts every output each cycle, plus directed literal checks.
module tb_syndrome_round_loader;
    localparam int PU = 100;
    localparam int TO = 100;
    localparam int M_LOAD = 0, M_DROP = 1, M_START = 2, M_WAIT = 3, M_HOLD = 4;

    logic clk;
    logic reset;
    logic [31:0] s_data;
    logic s_valid, s_last, s_ready, new_round_start;
    logic [PU-1:0] is_error_syndromes;
    logic result_valid;
    logic [31:0] cycle_counter;
    logic [7:0] iteration_counter;
    logic deadlock, final_cardinality, r_valid, r_ready;
    logic [15:0] r_round_id;
    logic [31:0] r_cycles;
    logic [7:0] r_iterations;
    logic r_deadlock, r_cardinality, r_timeout, framing_error;

    syndrome_round_loader #(
        .CODE_DISTANCE_X(5), .CODE_DISTANCE_Z(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .new_round_start(new_round_start),
        .is_error_syndromes(is_error_syndromes), .result_valid(result_valid),
        .cycle_counter(cycle_counter), .iteration_counter(iteration_counter),
        .deadlock(deadlock), .final_cardinality(final_cardinality),
        .r_valid(r_valid), .r_ready(r_ready), .r_round_id(r_round_id),
        .r_cycles(r_cycles), .r_iterations(r_iterations), .r_deadlock(r_deadlock),
        .r_cardinality(r_cardinality), .r_timeout(r_timeout), .framing_error(framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    int ph, widx, age;
    bit m_acc;
    logic exp_ready, exp_pulse, exp_fe, exp_rvalid, exp_dl, exp_card, exp_to;
    logic [PU-1:0] exp_syn;
    logic [15:0] exp_rid;
    logic [31:0] exp_cyc;
    logic [7:0] exp_it;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic bound_fail(input string nm);
        n_total++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    task automatic model_reset();
        ph = M_LOAD; widx = 0; age = 0; m_acc = 1'b0;
        exp_ready = 1'b0; exp_pulse = 1'b0; exp_fe = 1'b0; exp_rvalid = 1'b0;
        exp_syn = '0; exp_rid = '0; exp_cyc = '0; exp_it = '0;
        exp_dl = 1'b0; exp_card = 1'b0; exp_to = 1'b0;
    endtask

    task automatic capture(input bit t);
        exp_rvalid = 1'b1;
        exp_cyc = cycle_counter;
        exp_it = iteration_counter;
        exp_dl = deadlock | t;
        exp_card = final_cardinality;
        exp_to = t;
        ph = M_HOLD;
    endtask

    task automatic model_step();
        bit acc;
        acc = s_valid && exp_ready;
        m_acc = acc;
        case (ph)
            M_LOAD: if (acc) begin
                for (int b = 0; b < 32; b++)
                    if (widx * 32 + b < PU) exp_syn[widx * 32 + b] = s_data[b];
                if (widx == 3) begin
                    widx = 0;
                    if (s_last) ph = M_START;
                    else begin exp_fe = 1'b1; ph = M_DROP; end
                end else if (s_last) begin
                    exp_fe = 1'b1; widx = 0;
                end else widx++;
            end
            M_DROP: if (acc && s_last) ph = M_LOAD;
            M_START: begin ph = M_WAIT; age = 0; end
            M_WAIT: begin
                if (age >= 1 && result_valid) capture(1'b0);
                else if (age == TO) capture(1'b1);
                else age++;
            end
            M_HOLD: if (r_ready) begin exp_rvalid = 1'b0; exp_rid++; ph = M_LOAD; end
            default: ph = M_LOAD;
        endcase
        exp_ready = (ph == M_LOAD) || (ph == M_DROP);
        exp_pulse = (ph == M_START);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("s_ready", s_ready, exp_ready);
            chk("new_round_start", new_round_start, exp_pulse);
            chk("is_error_syndromes", is_error_syndromes, exp_syn);
            chk("framing_error", framing_error, exp_fe);
            chk("r_valid", r_valid, exp_rvalid);
            chk("r_round_id", r_round_id, exp_rid);
            chk("r_cycles", r_cycles, exp_cyc);
            chk("r_iterations", r_iterations, exp_it);
            chk("r_deadlock", r_deadlock, exp_dl);
            chk("r_cardinality", r_cardinality, exp_card);
            chk("r_timeout", r_timeout, exp_to);
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic rand_stats();
        cycle_counter = $urandom;
        iteration_counter = 8'($urandom);
        deadlock = 1'($urandom);
        final_cardinality = 1'($urandom);
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        s_data = d; s_valid = 1'b1; s_last = l; n = 0;
        do begin @(negedge clk); n++; end while (!m_acc && n < 200);
        if (!m_acc) bound_fail("send_word");
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_round(input logic [31:0] w0, w1, w2, w3);
        send_word(w0, 1'b0); gap();
        send_word(w1, 1'b0); gap();
        send_word(w2, 1'b0); gap();
        send_word(w3, 1'b1);
    endtask

    task automatic wait_rvalid();
        int n;
        n = 0;
        while (!exp_rvalid && n < 300) begin
            @(negedge clk); n++;
            if (!result_valid) rand_stats();
        end
        if (!exp_rvalid) bound_fail("wait_rvalid");
    endtask

    task automatic decode(input int lat, input bit never, input logic [31:0] c,
                          input logic [7:0] it, input logic dl, input logic card);
        result_valid = 1'b0;
        if (never) wait_rvalid();
        else begin
            repeat (lat) begin @(negedge clk); rand_stats(); end
            result_valid = 1'b1;
            cycle_counter = c; iteration_counter = it; deadlock = dl; final_cardinality = card;
            wait_rvalid();
            result_valid = 1'b0;
            rand_stats();
        end
    endtask

    task automatic consume(input int bp);
        repeat (bp) begin @(negedge clk); rand_stats(); end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    logic [PU-1:0] lit;
    logic [31:0] c0, c1, c2, c3;

    initial begin
        reset = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        result_valid = 1'b0; r_ready = 1'b0;
        cycle_counter = '0; iteration_counter = '0; deadlock = 1'b0; final_cardinality = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready_low", s_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_s_ready_high", s_ready, 1'b1);
        chk("rst_round_id", r_round_id, 16'd0);

        // Basic load plus result capture with backpressure
        lit = {4'hF, 32'h0, 32'h0, 32'h1};
        send_round(32'h1, 32'h0, 32'h0, 32'h0000000F);
        chk("basic_pulse", new_round_start, 1'b1);
        chk("basic_syn", is_error_syndromes, lit);
        decode(2, 1'b0, 32'd37, 8'd3, 1'b0, 1'b1);
        chk("cap_valid", r_valid, 1'b1);
        chk("cap_cycles", r_cycles, 32'd37);
        chk("cap_iter", r_iterations, 8'd3);
        chk("cap_deadlock", r_deadlock, 1'b0);
        chk("cap_card", r_cardinality, 1'b1);
        chk("cap_timeout", r_timeout, 1'b0);
        chk("cap_round_id", r_round_id, 16'd0);
        repeat (5) begin @(negedge clk); rand_stats(); end
        chk("bp_cycles", r_cycles, 32'd37);
        chk("bp_valid", r_valid, 1'b1);
        consume(0);
        chk("post_hs_ready", s_ready, 1'b1);

        // Upper bits of the last word are ignored; round id advances
        send_round(32'h1, 32'h0, 32'h0, 32'hFFFFFFFF);
        chk("upper_ignored_syn", is_error_syndromes, lit);
        decode(0, 1'b0, 32'd5, 8'd1, 1'b1, 1'b0);
        chk("second_round_id", r_round_id, 16'd1);
        consume(1);

        // Early s_last on word 2
        send_word(32'hDEAD0000, 1'b0);
        send_word(32'h0000BEEF, 1'b1);
        chk("early_fe", framing_error, 1'b1);
        chk("early_no_pulse", new_round_start, 1'b0);
        send_round($urandom, $urandom, $urandom, $urandom);
        decode(3, 1'b0, $urandom, 8'($urandom), 1'b0, 1'b1);
        consume(2);

        // Missing s_last: words 5 and 6 are dropped in resync
        repeat (4) send_word($urandom, 1'b0);
        send_word(32'hAAAAAAAA, 1'b0);
        send_word(32'h55555555, 1'b1);
        c0 = $urandom; c1 = $urandom; c2 = $urandom; c3 = $urandom;
        send_round(c0, c1, c2, c3);
        lit = {c3[3:0], c2, c1, c0};
        chk("resync_syn", is_error_syndromes, lit);
        decode(1, 1'b0, $urandom, 8'($urandom), 1'b0, 1'b0);
        consume(0);

        // Randomized rounds with framing faults and held s_valid
        for (int r = 0; r < 25; r++) begin
            int v;
            v = $urandom_range(0, 7);
            if (v == 0) begin
                int k;
                k = $urandom_range(1, 3);
                for (int j = 0; j < k - 1; j++) send_word($urandom, 1'b0);
                send_word($urandom, 1'b1);
            end else if (v == 1) begin
                int k;
                k = $urandom_range(0, 2);
                repeat (4) send_word($urandom, 1'b0);
                for (int j = 0; j < k; j++) send_word($urandom, 1'b0);
                send_word($urandom, 1'b1);
            end
            send_round($urandom, $urandom, $urandom, $urandom);
            if ($urandom_range(0, 1) == 1) begin
                s_valid = 1'b1; s_data = $urandom; s_last = 1'($urandom);
            end
            decode($urandom_range(0, 15), 1'b0, $urandom, 8'($urandom),
                   1'($urandom), 1'($urandom));
            consume($urandom_range(0, 4));
        end

        // Watchdog expiry
        send_round($urandom, $urandom, $urandom, $urandom);
        decode(0, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0);
        chk("wd_valid", r_valid, 1'b1);
        chk("wd_timeout", r_timeout, 1'b1);
        chk("wd_deadlock", r_deadlock, 1'b1);
        consume(2);

        // Reset in the middle of a decode
        send_round($urandom, $urandom, $urandom, $urandom);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ready", s_ready, 1'b0);
        chk("mid_rst_syn", is_error_syndromes, {PU{1'b0}});
        chk("mid_rst_fe", framing_error, 1'b0);
        chk("mid_rst_rvalid", r_valid, 1'b0);
        chk("mid_rst_rid", r_round_id, 16'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", s_ready, 1'b1);
        chk("post_rst_rid", r_round_id, 16'd0);
        send_round($urandom, $urandom, $urandom, $urandom);
        decode(4, 1'b0, $urandom, 8'($urandom), 1'b0, 1'b1);
        chk("post_rst_report_rid", r_round_id, 16'd0);
        consume(1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
